// File: rtl/mmcm_drp_sequencer_pkg.sv
// Shared definitions for the MMCM DRP reconfiguration sequencer.
//  - bit positions of the 64-bit reconfig_to_pll / reconfig_from_pll buses
//  - sequencer state enum
//  - latched DRP entry payload
//  - read-modify-write merge helper
package mmcm_drp_sequencer_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned BUS_W  = 64;

  // reconfig_to_pll bit positions
  localparam int unsigned DI_LSB    = 0;
  localparam int unsigned DADDR_LSB = 16;
  localparam int unsigned DEN       = 23;
  localparam int unsigned DWE       = 24;
  localparam int unsigned RST       = 25;
  localparam int unsigned DCLK      = 26;
  localparam int unsigned PAD_LSB   = 27;

  // reconfig_from_pll bit positions
  localparam int unsigned DO_LSB = 0;
  localparam int unsigned DRDY   = 16;
  localparam int unsigned LOCKED = 17;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    RD,
    RD_WAIT,
    WR,
    WR_WAIT,
    HOLD,
    LOCK_WAIT
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] data;
    logic              last;
  } drp_entry_t;

  // Mask bit 1 keeps the current register bit, 0 takes the new data bit.
  function automatic logic [DATA_W-1:0] drp_rmw(input logic [DATA_W-1:0] cur,
                                               input logic [DATA_W-1:0] mask,
                                               input logic [DATA_W-1:0] data);
    return (cur & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/mmcm_drp_sequencer_sync_2ff.sv
// Two-flop synchronizer for the MMCM locked indication.
//  clk  : destination clock
//  rst  : synchronous active-high reset, clears both stages
//  d    : asynchronous input
//  q    : synchronized output (2 clk latency)
module mmcm_drp_sequencer_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mmcm_drp_sequencer.sv
// DRP read-modify-write sequencer for the HDMI pixel-clock MMCM.
// Accepts (addr, mask, data, last) entries, applies each to the MMCM over DRP
// with the MMCM held in reset, then releases reset and waits for lock.
//  clk, rst            : clock and synchronous active-high reset
//  cfg_valid/cfg_ready : entry handshake (accept on valid & ready)
//  cfg_addr/mask/data  : DRP entry; mask bit 1 keeps, 0 replaces with data
//  cfg_last            : final entry of the reconfiguration
//  busy                : sequence in progress
//  done / err          : one-cycle completion / timeout pulses
//  reconfig_to_pll     : di, daddr, den, dwe, rst_mmcm, dclk; upper bits zero
//  reconfig_from_pll   : do, drdy, locked; upper bits ignored
module mmcm_drp_sequencer
  import mmcm_drp_sequencer_pkg::*;
#(
  parameter int unsigned DRDY_TIMEOUT = 255,
  parameter int unsigned LOCK_TIMEOUT = 1048575,
  parameter int unsigned RST_HOLD     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [BUS_W-1:0]  reconfig_to_pll,
  input  logic [BUS_W-1:0]  reconfig_from_pll
);

  localparam int unsigned TMO_MAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(TMO_MAX + 1);

  // RD_WAIT/WR_WAIT see DRDY_TIMEOUT+1 cycles; HOLD and LOCK_WAIT last exactly
  // RST_HOLD / LOCK_TIMEOUT cycles because the count includes the zero cycle.
  localparam logic [CNT_W-1:0] DRDY_LOAD = CNT_W'(DRDY_TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_TIMEOUT - 1);

  state_e            state;
  drp_entry_t        entry;
  logic [CNT_W-1:0]  cnt;
  logic              den;
  logic              dwe;
  logic              rst_mmcm;
  logic              done_r;
  logic              err_r;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] di;

  logic [DATA_W-1:0] drp_do;
  logic              drdy;
  logic              locked;
  logic              lock_sync;
  logic              accept;
  logic              cnt_zero;
  drp_entry_t        cfg_entry;
  logic              unused_from_pll;

  assign drp_do   = reconfig_from_pll[DO_LSB +: DATA_W];
  assign drdy     = reconfig_from_pll[DRDY];
  assign locked   = reconfig_from_pll[LOCKED];
  assign accept   = cfg_valid & cfg_ready;
  assign cnt_zero = (cnt == '0);

  assign unused_from_pll = ^reconfig_from_pll[BUS_W-1:LOCKED+1];

  assign cfg_entry = '{addr: cfg_addr, mask: cfg_mask, data: cfg_data, last: cfg_last};

  mmcm_drp_sequencer_sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (lock_sync)
  );

  // Sequencer FSM with registered bus and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      entry     <= '0;
      cnt       <= '0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      den       <= 1'b0;
      dwe       <= 1'b0;
      rst_mmcm  <= 1'b0;
      daddr     <= '0;
      di        <= '0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            entry     <= cfg_entry;
            daddr     <= cfg_addr;
            den       <= 1'b1;
            dwe       <= 1'b0;
            rst_mmcm  <= 1'b1;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
            state     <= RD;
          end else begin
            cfg_ready <= 1'b1;
          end
        end

        // Between entries: MMCM stays in reset for as long as the source stalls
        FETCH: begin
          if (accept) begin
            entry     <= cfg_entry;
            daddr     <= cfg_addr;
            den       <= 1'b1;
            dwe       <= 1'b0;
            cfg_ready <= 1'b0;
            state     <= RD;
          end else begin
            cfg_ready <= 1'b1;
          end
        end

        // drdy is not looked at here: a response in the den cycle is not valid
        RD: begin
          den   <= 1'b0;
          cnt   <= DRDY_LOAD;
          state <= RD_WAIT;
        end

        RD_WAIT: begin
          if (drdy) begin
            di    <= drp_rmw(drp_do, entry.mask, entry.data);
            daddr <= entry.addr;
            den   <= 1'b1;
            dwe   <= 1'b1;
            state <= WR;
          end else if (cnt_zero) begin
            rst_mmcm  <= 1'b0;
            busy      <= 1'b0;
            err_r     <= 1'b1;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        WR: begin
          den   <= 1'b0;
          dwe   <= 1'b0;
          cnt   <= DRDY_LOAD;
          state <= WR_WAIT;
        end

        WR_WAIT: begin
          if (drdy) begin
            if (entry.last) begin
              cnt   <= HOLD_LOAD;
              state <= HOLD;
            end else begin
              cfg_ready <= 1'b1;
              state     <= FETCH;
            end
          end else if (cnt_zero) begin
            rst_mmcm  <= 1'b0;
            busy      <= 1'b0;
            err_r     <= 1'b1;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        HOLD: begin
          if (cnt_zero) begin
            rst_mmcm <= 1'b0;
            cnt      <= LOCK_LOAD;
            state    <= LOCK_WAIT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        LOCK_WAIT: begin
          if (lock_sync) begin
            done_r    <= 1'b1;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end else if (cnt_zero) begin
            err_r     <= 1'b1;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pulses are suppressed for the whole cycle in which reset is asserted
  assign done = done_r & ~rst;
  assign err  = err_r & ~rst;

  // Bus assembly; dclk is the system clock forwarded to the MMCM
  always_comb begin
    reconfig_to_pll                        = '0;
    reconfig_to_pll[DI_LSB +: DATA_W]      = di;
    reconfig_to_pll[DADDR_LSB +: ADDR_W]   = daddr;
    reconfig_to_pll[DEN]                   = den;
    reconfig_to_pll[DWE]                   = dwe;
    reconfig_to_pll[RST]                   = rst_mmcm;
    reconfig_to_pll[DCLK]                  = clk;
  end

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Testbench for mmcm_drp_sequencer: behavioural MMCM/DRP model, a driver that
// pushes expected DRP accesses and end events into queues, and a monitor that
// pops and compares whenever the DUT issues an access or a done/err pulse.
module tb_mmcm_drp_sequencer;

  localparam int unsigned DRDY_TO = 255;
  localparam int unsigned LOCK_TO = 300;
  localparam int unsigned HOLD    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [6:0]  cfg_addr = '0;
  logic [15:0] cfg_mask = '0;
  logic [15:0] cfg_data = '0;
  logic        cfg_last = 1'b0;
  logic        busy, done, err;
  logic [63:0] to_pll;
  logic [63:0] from_pll;

  logic        drdy = 1'b0;
  logic        locked = 1'b0;
  logic [15:0] do_val = '0;
  logic [45:0] junk = '0;

  assign from_pll = {junk, locked, drdy, do_val};

  mmcm_drp_sequencer #(
    .DRDY_TIMEOUT (DRDY_TO),
    .LOCK_TIMEOUT (LOCK_TO),
    .RST_HOLD     (HOLD)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_valid         (cfg_valid),
    .cfg_ready         (cfg_ready),
    .cfg_addr          (cfg_addr),
    .cfg_mask          (cfg_mask),
    .cfg_data          (cfg_data),
    .cfg_last          (cfg_last),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .reconfig_to_pll   (to_pll),
    .reconfig_from_pll (from_pll)
  );

  always #5 clk = ~clk;

  logic        den, dwe, rst_mmcm;
  logic [6:0]  daddr;
  logic [15:0] di;
  assign di       = to_pll[15:0];
  assign daddr    = to_pll[22:16];
  assign den      = to_pll[23];
  assign dwe      = to_pll[24];
  assign rst_mmcm = to_pll[25];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at t=%0t", name, $time);
  endtask

  // Expected-event scoreboard
  typedef struct {
    bit          is_wr;
    logic [6:0]  addr;
    logic [15:0] data;
  } acc_t;

  acc_t exp_acc[$];
  int   exp_end[$];   // 0 done, 1 drdy timeout err, 2 lock timeout err

  logic [15:0] mem      [0:127];  // MMCM register file (written only by DUT)
  logic [15:0] ref_regs [0:127];  // reference view of the register file

  // MMCM / DRP behavioural model
  int   drdy_dly = 1;
  int   stall_read_at = -1;
  int   read_count = 0;
  int   lock_dly = 4;
  bit   lock_never = 1'b0;
  int   pend = 0;
  bit   pend_rd = 1'b0;
  logic [6:0] pend_addr = '0;
  int   lock_cnt = 0;
  int   lock_rise_cyc = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    drdy   = 1'b0;
    do_val = 16'($urandom);
    junk   = 46'({$urandom, $urandom});
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        drdy = 1'b1;
        if (pend_rd) do_val = mem[pend_addr];
      end
    end
    if (!rst && den) begin
      if (dwe) begin
        mem[daddr] = di;
        pend_rd    = 1'b0;
        pend       = drdy_dly;
      end else begin
        read_count++;
        pend_rd   = 1'b1;
        pend_addr = daddr;
        pend      = (read_count == stall_read_at) ? 0 : drdy_dly;
      end
    end
    if (rst_mmcm === 1'b1) begin
      locked   = 1'b0;
      lock_cnt = 0;
    end else if (!locked && !lock_never) begin
      lock_cnt++;
      if (lock_cnt >= lock_dly) begin
        locked        = 1'b1;
        lock_rise_cyc = cyc;
      end
    end
  end

  // Monitor
  bit den_prev = 1'b0, rstm_prev = 1'b0, busy_prev = 1'b0;
  int last_rd_cyc = 0, last_wr_cyc = 0, fall_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("no_pulse_in_rst", 64'({done, err}), 64'd0);
    end else begin
      check("bus_pad_zero", 64'(to_pll[63:27]), 64'd0);
      check("dclk_low", 64'(to_pll[26]), 64'd0);
      if (done && err) fail_now("done_and_err_together");
      if (den) begin
        check("den_width", 64'(den_prev), 64'd0);
        check("rst_mmcm_during_access", 64'(rst_mmcm), 64'd1);
        check("ready_low_during_access", 64'(cfg_ready), 64'd0);
        if (exp_acc.size() == 0) begin
          fail_now("unexpected_access");
        end else begin
          acc_t e;
          e = exp_acc.pop_front();
          check("acc_kind", 64'(dwe), 64'(e.is_wr));
          check("acc_addr", 64'(daddr), 64'(e.addr));
          if (e.is_wr) check("write_data", 64'(di), 64'(e.data));
        end
        if (!dwe) begin
          last_rd_cyc = cyc;
        end else begin
          check("rd_to_wr_latency", 64'(cyc - last_rd_cyc), 64'(drdy_dly + 1));
          last_wr_cyc = cyc;
        end
      end
      if (rst_mmcm && !rstm_prev) begin
        check("rst_mmcm_rise_at_start", 64'({busy_prev, busy}), 64'b01);
      end
      if (!rst_mmcm && rstm_prev && busy) begin
        fall_cyc = cyc;
        check("hold_length", 64'(cyc - last_wr_cyc), 64'(drdy_dly + HOLD + 1));
      end
      if (done || err) begin
        if (exp_end.size() == 0) begin
          fail_now("unexpected_end_pulse");
        end else begin
          int k;
          k = exp_end.pop_front();
          check("end_kind_err", 64'(err), 64'(k != 0));
          check("end_busy_rst_mmcm", 64'({busy, rst_mmcm}), 64'd0);
          check("ready_after_end", 64'(cfg_ready), 64'd1);
          if (k == 0) check("done_latency", 64'(cyc - lock_rise_cyc), 64'd3);
          if (k == 1) check("drdy_timeout_latency", 64'(cyc - last_rd_cyc), 64'(DRDY_TO + 2));
          if (k == 2) check("lock_timeout_latency", 64'(cyc - fall_cyc), 64'(LOCK_TO));
        end
      end
    end
    den_prev  = den;
    rstm_prev = rst_mmcm;
    busy_prev = busy;
  end

  always @(posedge clk) begin
    #1;
    if (rst === 1'b0) check("dclk_high", 64'(to_pll[26]), 64'd1);
  end

  // Driver: offers one entry, records expectations at the accepting edge
  task automatic send(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                      input bit last, input bit exp_wr, input int gap);
    bit ok = 1'b0;
    acc_t e;
    repeat (gap) @(negedge clk);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_mask  = m;
    cfg_data  = d;
    cfg_last  = last;
    for (int n = 0; n < 2000; n++) begin
      if (cfg_ready) begin
        e.is_wr = 1'b0; e.addr = a; e.data = 16'h0;
        exp_acc.push_back(e);
        if (exp_wr) begin
          ref_regs[a] = (ref_regs[a] & m) | (d & ~m);
          e.is_wr = 1'b1; e.addr = a; e.data = ref_regs[a];
          exp_acc.push_back(e);
        end
        ok = 1'b1;
      end
      @(negedge clk);
      if (ok) break;
    end
    cfg_valid = 1'b0;
    cfg_addr  = 7'($urandom);
    cfg_mask  = 16'($urandom);
    cfg_data  = 16'($urandom);
    cfg_last  = 1'($urandom);
    if (!ok) fail_now("accept_timeout");
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    while ((exp_end.size() != 0 || exp_acc.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      fail_now(name);
      exp_end.delete();
      exp_acc.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  localparam logic [6:0] T2_ADDR [3] = '{7'h08, 7'h09, 7'h14};

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i]      = 16'($urandom);
      ref_regs[i] = mem[i];
    end

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_bus_low", 64'(to_pll[25:0]), 64'd0);
    check("rst_bus_pad", 64'(to_pll[63:27]), 64'd0);
    check("rst_status", 64'({cfg_ready, busy, done, err}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(cfg_ready), 64'd1);

    // Single entry, do=0xFFFF, drdy 2 cycles late
    mem[8] = 16'hFFFF; ref_regs[8] = 16'hFFFF;
    drdy_dly = 2; lock_dly = 4;
    send(7'h08, 16'h1000, 16'h0145, 1'b1, 1'b1, 0);
    exp_end.push_back(0);
    wait_idle(500, "t1_timeout");
    check("t1_mem_08", 64'(mem[8]), 64'h1145);

    // Three-entry stream with 5-cycle valid gaps
    drdy_dly = 1;
    for (int i = 0; i < 3; i++)
      send(T2_ADDR[i], 16'($urandom), 16'($urandom), i == 2, 1'b1, 5);
    exp_end.push_back(0);
    wait_idle(500, "t2_timeout");

    // Randomized sequences, small address range to chain RMWs on one register
    for (int s = 0; s < 6; s++) begin
      int n;
      n        = $urandom_range(1, 4);
      drdy_dly = $urandom_range(1, 4);
      lock_dly = $urandom_range(1, 20);
      for (int i = 0; i < n; i++)
        send(7'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), i == n - 1, 1'b1,
             $urandom_range(0, 3));
      exp_end.push_back(0);
      wait_idle(1000, "rand_timeout");
    end
    for (int i = 0; i < 16; i++) check("rand_mem", 64'(mem[i]), 64'(ref_regs[i]));

    // drdy never returns on the 2nd read
    drdy_dly = 2;
    stall_read_at = read_count + 2;
    send(7'h21, 16'($urandom), 16'($urandom), 1'b0, 1'b1, 0);
    send(7'h22, 16'($urandom), 16'($urandom), 1'b1, 1'b0, 0);
    exp_end.push_back(1);
    wait_idle(1000, "t3_timeout");
    stall_read_at = -1;
    check("t3_mem_22_untouched", 64'(mem[7'h22]), 64'(ref_regs[7'h22]));

    // Lock never arrives, then a new sequence is accepted straight away
    drdy_dly = 1;
    lock_never = 1'b1;
    send(7'h30, 16'($urandom), 16'($urandom), 1'b1, 1'b1, 0);
    exp_end.push_back(2);
    wait_idle(1000, "t4_timeout");
    lock_never = 1'b0;
    lock_dly = 3;
    send(7'h31, 16'($urandom), 16'($urandom), 1'b1, 1'b1, 0);
    exp_end.push_back(0);
    wait_idle(500, "t4b_timeout");

    // Reset pulsed during WR_WAIT
    drdy_dly = 6;
    send(7'h40, 16'($urandom), 16'($urandom), 1'b1, 1'b1, 0);
    begin
      bool_wr: for (int n = 0; n < 50; n++) begin
        if (den && dwe) break;
        @(negedge clk);
        if (n == 49) fail_now("t5_no_write");
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_after_rst", 64'({den, dwe, rst_mmcm, busy, cfg_ready}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_no_pulse", 64'({done, err}), 64'd0);
    check("t5_queues_empty", 64'(exp_acc.size() + exp_end.size()), 64'd0);
    repeat (10) @(negedge clk);
    drdy_dly = 1;
    send(7'h41, 16'($urandom), 16'($urandom), 1'b0, 1'b1, 0);
    send(7'h40, 16'($urandom), 16'($urandom), 1'b1, 1'b1, 1);
    exp_end.push_back(0);
    wait_idle(500, "t5b_timeout");

    check("final_queues_empty", 64'(exp_acc.size() + exp_end.size()), 64'd0);
    check("final_idle", 64'({busy, cfg_ready}), 64'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
